// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- interrupt source block feeding the cop0 hard-interrupt vector.
//
// Collects six asynchronous peripheral IRQ lines plus an internal
// COUNT/COMPARE timer, latches them into a software-visible PENDING register
// (per-bit edge/level selection, write-1-to-clear), masks the result with
// MASK and drives a registered hard_int[5:0] vector.
//
// Register map (word index on addr):
//   0 PENDING  R/W1C  [5:0] = latched sources | (timer_pend << TIMER_LINE)
//   1 MASK     RW     [5:0]
//   2 EDGE     RW     [5:0]  1 = rising-edge source, 0 = level source
//   3 COUNT    RW     free-running 32-bit counter, write loads it
//   4 COMPARE  RW     timer match value, 0 disables, write clears timer_pend
//   5 PRESCALE RW     [7:0], only with INT_CTRL_PRESCALE_EN, else reads 0
//   6-7        reserved, read 0, writes ignored
//
// Optional feature macro: INT_CTRL_PRESCALE_EN
//   Adds an 8-bit PRESCALE register; COUNT then advances once every
//   PRESCALE+1 cycles and the compare match is only evaluated while COUNT
//   holds a freshly updated value.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   irq_in    [5:0] asynchronous peripheral requests, active-high
//   addr      [2:0] register select
//   reg_wr    write strobe, in_data captured on the clock edge
//   reg_rd    read strobe
//   in_data   [31:0] write data
//   out_data  [31:0] read data, combinational, 0 when reg_rd is low
//   hard_int  [5:0] registered interrupt vector to cop0
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_LINE  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  irq_in,
  input  logic [2:0]  addr,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [31:0] in_data,
  output logic [31:0] out_data,
  output logic [5:0]  hard_int
);

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE     = 3'd2;
  localparam logic [2:0] ADDR_COUNT    = 3'd3;
  localparam logic [2:0] ADDR_COMPARE  = 3'd4;
  localparam logic [2:0] ADDR_PRESCALE = 3'd5;

  // Synchronizer chain and edge-detect history
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [5:0]  prev_q;
  logic [5:0]  sync_s;

  // Software-visible state
  logic [5:0]  pending_q;
  logic [5:0]  mask_q;
  logic [5:0]  edge_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_pend_q;

  // Write decodes
  logic wr_pending;
  logic wr_mask;
  logic wr_edge;
  logic wr_count;
  logic wr_compare;

  logic [5:0]  set_vec;
  logic [5:0]  clr_vec;
  logic [5:0]  timer_vec;
  logic [5:0]  pending_view;
  logic        match_en;
  logic [31:0] rd_val;

  assign wr_pending = reg_wr && (addr == ADDR_PENDING);
  assign wr_mask    = reg_wr && (addr == ADDR_MASK);
  assign wr_edge    = reg_wr && (addr == ADDR_EDGE);
  assign wr_count   = reg_wr && (addr == ADDR_COUNT);
  assign wr_compare = reg_wr && (addr == ADDR_COMPARE);

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Edge sources fire on a 0->1 of the synchronized line, level sources fire
  // every cycle the line is high (so a clear while still high re-asserts).
  assign set_vec      = (edge_q & sync_s & ~prev_q) | (~edge_q & sync_s);
  assign clr_vec      = wr_pending ? in_data[5:0] : 6'h00;
  assign timer_vec    = timer_pend_q ? (6'b000001 << TIMER_LINE) : 6'h00;
  assign pending_view = pending_q | timer_vec;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  // NOTE: the chain and prev sample are reset like any other flop; clearing
  // prev_q means a line held high through reset is seen as a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_s;
    end
  end

  // ---------------------------------------------------------------------------
  // PENDING / MASK / EDGE / hard_int
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      hard_int  <= '0;
    end else begin
      // A new set beats a simultaneous write-1-to-clear.
      pending_q <= set_vec | (pending_q & ~clr_vec);
      if (wr_mask) mask_q <= in_data[5:0];
      if (wr_edge) edge_q <= in_data[5:0];
      hard_int  <= pending_view & mask_q;
    end
  end

  // ---------------------------------------------------------------------------
  // COUNT / COMPARE timer
  // ---------------------------------------------------------------------------
`ifdef INT_CTRL_PRESCALE_EN
  logic [7:0] prescale_q;
  logic [7:0] div_q;
  logic       tick;
  logic       wr_prescale;
  logic       count_fresh_q;

  assign wr_prescale = reg_wr && (addr == ADDR_PRESCALE);
  assign tick        = (div_q == prescale_q);
  // Only a COUNT value that was just produced may raise a match, otherwise a
  // slow counter would re-raise timer_pend right after software cleared it.
  assign match_en    = count_fresh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q    <= '0;
      div_q         <= '0;
      count_q       <= '0;
      count_fresh_q <= 1'b0;
    end else begin
      if (wr_prescale) prescale_q <= in_data[7:0];

      if (wr_count)  count_q <= in_data;
      else if (tick) count_q <= count_q + 32'd1;

      if (wr_count || wr_prescale || tick) div_q <= '0;
      else                                 div_q <= div_q + 8'd1;

      count_fresh_q <= wr_count || tick;
    end
  end
`else
  assign match_en = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= in_data;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q    <= '0;
      timer_pend_q <= 1'b0;
    end else begin
      if (wr_compare) compare_q <= in_data;
      // A COMPARE write clears the sticky flag and wins over a match.
      if (wr_compare) begin
        timer_pend_q <= 1'b0;
      end else if (match_en && (compare_q != 32'd0) && (count_q == compare_q)) begin
        timer_pend_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (no side effects, shows pre-write values)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns rd_val and no latch is inferred.
    rd_val = '0;
    case (addr)
      ADDR_PENDING:  rd_val[5:0] = pending_view;
      ADDR_MASK:     rd_val[5:0] = mask_q;
      ADDR_EDGE:     rd_val[5:0] = edge_q;
      ADDR_COUNT:    rd_val      = count_q;
      ADDR_COMPARE:  rd_val      = compare_q;
`ifdef INT_CTRL_PRESCALE_EN
      ADDR_PRESCALE: rd_val[7:0] = prescale_q;
`endif
      default:       rd_val      = '0;
    endcase
  end

  assign out_data = reg_rd ? rd_val : 32'd0;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl -- self-checking bench for int_ctrl.
// A behavioural model tracks the block from its register-level rules: a
// history queue of sampled irq_in values stands in for the synchronizer, and
// the pending/timer/mask rules are applied once per clock edge. Directed steps
// follow the test plan, then a randomized phase compares every cycle.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  localparam int SS = 2;
  localparam int TL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq_in;
  logic [2:0]  addr;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic [5:0]  hard_int;

  int checks = 0;
  int errors = 0;

  int_ctrl #(.SYNC_STAGES(SS), .TIMER_LINE(TL)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .addr     (addr),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .in_data  (in_data),
    .out_data (out_data),
    .hard_int (hard_int)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [5:0]  hist[$];   // hist[0] = irq_in sampled at the latest edge
  logic [5:0]  m_pend, m_mask, m_edge, m_hint;
  logic [31:0] m_count, m_cmp;
  logic        m_tp;
  logic [7:0]  m_pre, m_div;
  logic        m_fresh;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i <= SS; i++) hist.push_back(6'h00);
    m_pend = 0; m_mask = 0; m_edge = 0; m_hint = 0;
    m_count = 0; m_cmp = 0; m_tp = 0;
    m_pre = 0; m_div = 0; m_fresh = 0;
  endtask

  function automatic logic [5:0] timer_bits(logic tp);
    return tp ? 6'(1 << TL) : 6'h00;
  endfunction

  function automatic logic [31:0] model_read(logic [2:0] a);
    case (a)
      3'd0: return {26'd0, m_pend | timer_bits(m_tp)};
      3'd1: return {26'd0, m_mask};
      3'd2: return {26'd0, m_edge};
      3'd3: return m_count;
      3'd4: return m_cmp;
`ifdef INT_CTRL_PRESCALE_EN
      3'd5: return {24'd0, m_pre};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Applies one clock edge using the inputs currently driven.
  task automatic model_update();
    logic [5:0]  s, p, set, clr, n_pend;
    logic        w0, w1, w2, w3, w4, w5, tick, match, n_tp;
    logic [31:0] n_count;
    if (rst) begin
      model_reset();
      return;
    end
    s = hist[SS-1];
    p = hist[SS];
    for (int i = 0; i < 6; i++)
      set[i] = m_edge[i] ? (s[i] && !p[i]) : s[i];
    w0 = reg_wr && addr == 0; w1 = reg_wr && addr == 1; w2 = reg_wr && addr == 2;
    w3 = reg_wr && addr == 3; w4 = reg_wr && addr == 4; w5 = reg_wr && addr == 5;
    clr    = w0 ? in_data[5:0] : 6'h00;
    n_pend = set | (m_pend & ~clr);
    m_hint = (m_pend | timer_bits(m_tp)) & m_mask;
`ifdef INT_CTRL_PRESCALE_EN
    tick  = (m_div == m_pre);
    match = m_fresh && m_cmp != 0 && m_count == m_cmp;
    n_count = w3 ? in_data : (tick ? m_count + 1 : m_count);
    m_div   = (w3 || w5 || tick) ? 8'd0 : m_div + 8'd1;
    m_fresh = w3 || tick;
    if (w5) m_pre = in_data[7:0];
`else
    tick  = 1'b1;
    match = m_cmp != 0 && m_count == m_cmp;
    n_count = w3 ? in_data : m_count + 1;
`endif
    n_tp = w4 ? 1'b0 : (match ? 1'b1 : m_tp);
    if (w1) m_mask = in_data[5:0];
    if (w2) m_edge = in_data[5:0];
    if (w4) m_cmp  = in_data;
    m_pend  = n_pend;
    m_count = n_count;
    m_tp    = n_tp;
    hist.push_front(irq_in);
    void'(hist.pop_back());
  endtask

  // ---------------- checking / stimulus helpers ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("hard_int_vs_model", {26'd0, hard_int}, {26'd0, m_hint});
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    addr = a; in_data = d; reg_wr = 1'b1;
    step();
    reg_wr = 1'b0;
  endtask

  task automatic rd_expect(string tag, logic [2:0] a, logic [31:0] exp);
    addr = a; reg_rd = 1'b1;
    #1;
    check(tag, out_data, exp);
    reg_rd = 1'b0;
  endtask

  task automatic rd_model(string tag, logic [2:0] a);
    addr = a; reg_rd = 1'b1;
    #1;
    check(tag, out_data, model_read(a));
    reg_rd = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; irq_in = 6'h00; addr = 3'd0; reg_wr = 1'b0; reg_rd = 1'b0; in_data = 32'd0;
    model_reset();

    // Reset: sources toggling while held in reset
    irq_in = 6'h3F;
    steps(3);
    check("reset_hard_int", {26'd0, hard_int}, 32'd0);
    check("reset_rd_idle", out_data, 32'd0);
    for (int a = 0; a < 8; a++) rd_expect("reset_reg", 3'(a), 32'd0);
    rst = 1'b0;
    steps(3);
    rd_expect("post_reset_pending", 3'd0, 32'h3F);
    check("post_reset_hard_int", {26'd0, hard_int}, 32'd0);

    // Edge latency
    irq_in = 6'h00;
    steps(3);
    wr(3'd0, 32'h3F);
    rd_expect("w1c_all", 3'd0, 32'h00);
    wr(3'd1, 32'h01);
    wr(3'd2, 32'h01);
    steps(2);
    irq_in = 6'h01;
    step();                                     // edge k
    step();                                     // k+1
    rd_expect("edge_k1_pending", 3'd0, 32'h00);
    step();                                     // k+2
    rd_expect("edge_k2_pending", 3'd0, 32'h01);
    check("edge_k2_hard_int", {26'd0, hard_int}, 32'h00);
    step();                                     // k+3
    check("edge_k3_hard_int", {26'd0, hard_int}, 32'h01);
    wr(3'd0, 32'h01);
    rd_expect("edge_cleared", 3'd0, 32'h00);
    steps(3);
    rd_expect("edge_stays_clear", 3'd0, 32'h00);

    // Level reassert
    wr(3'd1, 32'h02);
    wr(3'd2, 32'h00 | 32'h01);                  // bit0 stays edge, bit1 level
    irq_in = 6'h03;
    steps(4);
    wr(3'd0, 32'h02);
    rd_expect("level_reassert", 3'd0, 32'h02);
    irq_in = 6'h01;
    steps(3);
    wr(3'd0, 32'h02);
    rd_expect("level_cleared", 3'd0, 32'h00);
    check("level_hint_lag", {26'd0, hard_int}, 32'h02);
    step();
    check("level_hint_off", {26'd0, hard_int}, 32'h00);

    // Set-vs-clear race on bit 2
    wr(3'd2, 32'h05);
    irq_in = 6'h05;
    step();                                     // k
    step();                                     // k+1
    wr(3'd0, 32'h04);                           // k+2: set and W1C together
    rd_expect("race_set_wins", 3'd0, 32'h04);

    // Timer
    wr(3'd0, 32'h3F);
    wr(3'd1, 32'h20);
    wr(3'd3, 32'hFFFF_FFFE);
    wr(3'd4, 32'd3);                            // COUNT now 0xFFFFFFFF
    steps(4);
    rd_expect("timer_wrapped_count", 3'd3, 32'd3);
    rd_expect("timer_not_yet", 3'd0, 32'h00);
    step();
    rd_expect("timer_pend", 3'd0, 32'h20);
    check("timer_hint_lag", {26'd0, hard_int}, 32'h00);
    step();
    check("timer_hint_on", {26'd0, hard_int}, 32'h20);
    wr(3'd0, 32'h20);
    rd_expect("timer_w1c_ignored", 3'd0, 32'h20);
    wr(3'd4, 32'd100);
    rd_expect("timer_cleared", 3'd0, 32'h00);
    check("timer_hint_still", {26'd0, hard_int}, 32'h20);
    step();
    check("timer_hint_off", {26'd0, hard_int}, 32'h00);

`ifdef INT_CTRL_PRESCALE_EN
    wr(3'd5, 32'd3);
    wr(3'd3, 32'd0);
    steps(4);
    rd_expect("prescale_count1", 3'd3, 32'd1);
    steps(4);
    rd_expect("prescale_count2", 3'd3, 32'd2);
`else
    wr(3'd5, 32'hFF);
    rd_expect("prescale_absent", 3'd5, 32'd0);
`endif

    // Randomized phase against the model
    for (int n = 0; n < 800; n++) begin
      logic [2:0]  a;
      logic [31:0] d;
      irq_in = 6'($urandom);
      if (n == 400) begin
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_reset_hard_int", {26'd0, hard_int}, 32'd0);
        step();
        rst = 1'b0;
      end
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd3 || a == 3'd4) d = $urandom_range(0, 40);
      if (a == 3'd5) d = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        addr = a; in_data = d; reg_wr = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          reg_rd = 1'b1;
          #1;
          check("rand_rd_during_wr", out_data, model_read(a));
          reg_rd = 1'b0;
        end
        step();
        reg_wr = 1'b0;
      end else begin
        step();
      end
      if ($urandom_range(0, 2) == 0) rd_model("rand_rd", 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
